switch_allocator: RTL and testbench

- Per-outport wormhole allocator for the chiplet switch.
- Input buffers request an output port. A round-robin arbiter per outport grants one buffer. The outport stays locked to that buffer until its tail flit leaves.
- Drives crossbar select/enable and returns a one-cycle grant pulse to the winning buffer.

---
 rtl/switch_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/switch_allocator.sv | 118 +++++++++++
 tb/tb_switch_allocator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and helpers for the switch allocator slice.
package switch_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

  // Index width that stays at least one bit wide for single-entry vectors.
  function automatic int idx_width(input int n);
    return $clog2(n) + ((n == 1) ? 1 : 0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first set request above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] request,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] winner_idx,
  output logic         any_valid
);

  always_comb begin
    int unsigned idx_full;
    logic [W-1:0] idx;
    onehot     = '0;
    winner_idx = '0;
    any_valid  = 1'b0;
    idx_full   = 0;
    idx        = '0;
    for (int k = 1; k <= N; k++) begin
      idx_full = (32'(ptr) + 32'(k)) % 32'(N);
      idx      = W'(idx_full);
      if (!any_valid && request[idx]) begin
        any_valid   = 1'b1;
        onehot[idx] = 1'b1;
        winner_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-outport wormhole allocator: round-robin grant, lock until tail release.
//
// state     | meaning
// ST_IDLE   | outport free, arbitrates among eligible requesters each cycle
// ST_LOCKED | outport held by select[p] until that buffer pulses release_tail
module switch_allocator
  import switch_pkg::*;
#(
  parameter int NUM_BUFFERS  = 4,
  parameter int NUM_OUTPORTS = 4,
  parameter int REQUEST_SIZE = idx_width(NUM_OUTPORTS),
  parameter int SELECT_SIZE  = idx_width(NUM_BUFFERS)
) (
  input  logic                                CLK,
  input  logic                                nRST,
  input  logic [NUM_BUFFERS-1:0]              req,
  input  logic [NUM_BUFFERS*REQUEST_SIZE-1:0] req_port,
  input  logic [NUM_BUFFERS-1:0]              release_tail,
  output logic [NUM_BUFFERS-1:0]              grant,
  output logic [NUM_OUTPORTS*SELECT_SIZE-1:0] select,
  output logic [NUM_OUTPORTS-1:0]             enable,
  output logic [NUM_BUFFERS-1:0]              owned
);

  alloc_state_e           state_q   [NUM_OUTPORTS];
  alloc_state_e           state_nxt [NUM_OUTPORTS];
  logic [SELECT_SIZE-1:0] rr_ptr_q  [NUM_OUTPORTS];
  logic [SELECT_SIZE-1:0] rr_ptr_nxt[NUM_OUTPORTS];
  logic [SELECT_SIZE-1:0] sel_q     [NUM_OUTPORTS];
  logic [SELECT_SIZE-1:0] sel_nxt   [NUM_OUTPORTS];
  logic [NUM_BUFFERS-1:0] grant_q, grant_nxt;
  logic [NUM_BUFFERS-1:0] owned_q, owned_nxt;

  logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0] elig;
  logic [NUM_BUFFERS-1:0] win_oh  [NUM_OUTPORTS];
  logic [SELECT_SIZE-1:0] win_idx [NUM_OUTPORTS];
  logic [NUM_OUTPORTS-1:0] win_any;

  // Out-of-range req_port values never match any p, so they are never granted.
  always_comb begin
    elig = '0;
    for (int p = 0; p < NUM_OUTPORTS; p++) begin
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        elig[p][i] = req[i] && !owned_q[i] &&
                     (req_port[i*REQUEST_SIZE +: REQUEST_SIZE] == REQUEST_SIZE'(p));
      end
    end
  end

  for (genvar gp = 0; gp < NUM_OUTPORTS; gp++) begin : g_port
    rr_arbiter #(
      .N (NUM_BUFFERS),
      .W (SELECT_SIZE)
    ) u_rr_arbiter (
      .request    (elig[gp]),
      .ptr        (rr_ptr_q[gp]),
      .onehot     (win_oh[gp]),
      .winner_idx (win_idx[gp]),
      .any_valid  (win_any[gp])
    );

    assign select[gp*SELECT_SIZE +: SELECT_SIZE] = sel_q[gp];
    assign enable[gp] = (state_q[gp] == ST_LOCKED);
  end

  // A locked port ignores requests, so a release always leaves a one-cycle bubble.
  always_comb begin
    grant_nxt = '0;
    owned_nxt = owned_q;
    for (int p = 0; p < NUM_OUTPORTS; p++) begin
      state_nxt[p]  = state_q[p];
      sel_nxt[p]    = sel_q[p];
      rr_ptr_nxt[p] = rr_ptr_q[p];
      case (state_q[p])
        ST_IDLE: begin
          if (win_any[p]) begin
            state_nxt[p]  = ST_LOCKED;
            sel_nxt[p]    = win_idx[p];
            rr_ptr_nxt[p] = win_idx[p];
            grant_nxt     = grant_nxt | win_oh[p];
            owned_nxt     = owned_nxt | win_oh[p];
          end
        end
        ST_LOCKED: begin
          if (release_tail[sel_q[p]]) begin
            state_nxt[p]        = ST_IDLE;
            owned_nxt[sel_q[p]] = 1'b0;
          end
        end
        default: state_nxt[p] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grant_q <= '0;
      owned_q <= '0;
      for (int p = 0; p < NUM_OUTPORTS; p++) begin
        state_q[p]  <= ST_IDLE;
        sel_q[p]    <= '0;
        rr_ptr_q[p] <= SELECT_SIZE'(NUM_BUFFERS - 1);
      end
    end else begin
      grant_q <= grant_nxt;
      owned_q <= owned_nxt;
      for (int p = 0; p < NUM_OUTPORTS; p++) begin
        state_q[p]  <= state_nxt[p];
        sel_q[p]    <= sel_nxt[p];
        rr_ptr_q[p] <= rr_ptr_nxt[p];
      end
    end
  end

  assign grant = grant_q;
  assign owned = owned_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: reset, arbitration order, locking, collisions, aborts.
module tb_switch_allocator;

  logic       clk_sys = 1'b0;
  logic       rst_b;
  logic [3:0] req, release_tail, grant, enable, owned;
  logic [7:0] req_port, select;

  // Three-outport instance: a 2-bit req_port value of 3 is out of range here.
  logic [3:0] req3, release3, grant3, owned3;
  logic [7:0] req_port3;
  logic [5:0] select3;
  logic [2:0] enable3;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  switch_allocator #(.NUM_BUFFERS(4), .NUM_OUTPORTS(4)) dut (
    .CLK          (clk_sys),
    .nRST         (rst_b),
    .req          (req),
    .req_port     (req_port),
    .release_tail (release_tail),
    .grant        (grant),
    .select       (select),
    .enable       (enable),
    .owned        (owned)
  );

  switch_allocator #(.NUM_BUFFERS(4), .NUM_OUTPORTS(3)) dut3 (
    .CLK          (clk_sys),
    .nRST         (rst_b),
    .req          (req3),
    .req_port     (req_port3),
    .release_tail (release3),
    .grant        (grant3),
    .select       (select3),
    .enable       (enable3),
    .owned        (owned3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    req = '0; req_port = '0; release_tail = '0;
    req3 = '0; req_port3 = '0; release3 = '0;
    repeat (2) @(posedge clk_sys);
    #1;
    rst_b = 1'b1;
  endtask

  initial begin
    rst_b = 1'b0;
    req = 4'b1111; req_port = 8'b01_01_01_01; release_tail = '0;
    req3 = '0; req_port3 = '0; release3 = '0;

    // Reset held with all buffers requesting port 1.
    tick(); tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_enable", 32'(enable), 32'h0);
    chk("rst_owned", 32'(owned), 32'h0);
    chk("rst_select", 32'(select), 32'h0);
    rst_b = 1'b1;
    tick();
    chk("rst_first_grant", 32'(grant), 32'b0001);
    chk("rst_first_sel1", 32'(select[3:2]), 32'd0);
    req = 4'b1110;
    tick();
    chk("rst_locked_nogrant", 32'(grant), 32'h0);

    // Single request, then tail release.
    do_reset();
    req = 4'b0100; req_port = 8'b00_01_00_00;
    tick();
    chk("single_grant", 32'(grant), 32'b0100);
    chk("single_enable", 32'(enable), 32'b0010);
    chk("single_sel1", 32'(select[3:2]), 32'd2);
    chk("single_owned", 32'(owned), 32'b0100);
    req = '0;
    tick();
    chk("single_pulse", 32'(grant), 32'h0);
    release_tail = 4'b0100;
    tick();
    release_tail = '0;
    chk("single_rel_enable", 32'(enable), 32'h0);
    chk("single_rel_owned", 32'(owned), 32'h0);
    chk("single_sel_hold", 32'(select[3:2]), 32'd2);

    // Round-robin between buffers 0 and 2 on port 1.
    do_reset();
    req = 4'b0101; req_port = 8'b00_01_00_01;
    tick();
    chk("rr_grant0", 32'(grant), 32'b0001);
    req = 4'b0100;
    tick();
    chk("rr_wait_a", 32'(grant), 32'h0);
    tick();
    chk("rr_wait_b", 32'(grant), 32'h0);
    release_tail = 4'b0001;
    tick();
    release_tail = '0;
    chk("rr_bubble_a", 32'(grant), 32'h0);
    chk("rr_bubble_en_a", 32'(enable), 32'h0);
    tick();
    chk("rr_grant2", 32'(grant), 32'b0100);
    chk("rr_sel1_2", 32'(select[3:2]), 32'd2);
    req = 4'b0001;
    tick(); tick();
    chk("rr_locked_b", 32'(grant), 32'h0);
    release_tail = 4'b0100;
    tick();
    release_tail = '0;
    chk("rr_bubble_b", 32'(grant), 32'h0);
    tick();
    chk("rr_grant0_again", 32'(grant), 32'b0001);
    chk("rr_sel1_0", 32'(select[3:2]), 32'd0);

    // Parallel ports.
    do_reset();
    req = 4'b0011; req_port = 8'b00_00_00_11;
    tick();
    chk("par_grant", 32'(grant), 32'b0011);
    chk("par_enable", 32'(enable), 32'b1001);
    chk("par_sel3", 32'(select[7:6]), 32'd0);
    chk("par_sel0", 32'(select[1:0]), 32'd1);
    chk("par_owned", 32'(owned), 32'b0011);

    // Release and new request colliding on port 2.
    do_reset();
    req = 4'b1000; req_port = 8'b10_00_00_00;
    tick();
    chk("col_lock", 32'(grant), 32'b1000);
    req = 4'b0010; req_port = 8'b00_00_10_00; release_tail = 4'b1000;
    tick();
    release_tail = '0;
    chk("col_m1_enable", 32'(enable[2]), 32'h0);
    chk("col_m1_grant", 32'(grant), 32'h0);
    tick();
    chk("col_m2_grant", 32'(grant), 32'b0010);
    chk("col_m2_sel2", 32'(select[5:4]), 32'd1);

    // Ignored release from non-owner while locked.
    req = '0; release_tail = 4'b0001;
    tick();
    release_tail = '0;
    chk("nonowner_rel", 32'(enable[2]), 32'h1);

    // Asynchronous abort while port 0 is locked.
    do_reset();
    req = 4'b0010; req_port = 8'b00_00_00_00;
    tick();
    chk("abort_locked", 32'(enable), 32'b0001);
    req = '0;
    #2;
    rst_b = 1'b0;
    #1;
    chk("abort_enable", 32'(enable), 32'h0);
    chk("abort_owned", 32'(owned), 32'h0);
    #1;
    rst_b = 1'b1;
    release_tail = 4'b0010;
    tick();
    release_tail = '0;
    chk("abort_rel_grant", 32'(grant), 32'h0);
    chk("abort_rel_enable", 32'(enable), 32'h0);
    tick();
    chk("abort_no_grant", 32'(grant), 32'h0);

    // Out-of-range port on the three-outport instance.
    do_reset();
    req3 = 4'b0011; req_port3 = 8'b00_00_10_11;
    tick();
    chk("ill_legal_grant", 32'(grant3), 32'b0010);
    chk("ill_legal_enable", 32'(enable3), 32'b100);
    for (int c = 0; c < 5; c++) begin
      req3 = 4'b0001;
      tick();
      chk("ill_no_grant", 32'(grant3[0]), 32'h0);
    end
    chk("ill_owned", 32'(owned3), 32'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
